// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_N_DEFAULT = 32;

  // Counter must hold values up to n so a full run of n iterations is representable.
  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cntWidth(DIV_N_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on an (N+1)-bit partial remainder;
// a subtract without borrow produces quotient bit 1 and keeps the difference.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   i_rem,
  input  logic         i_dividendBit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_rem,
  output logic         o_qBit
);

  logic [N+1:0] w_diff;
  logic [N:0]   w_shifted;

  assign w_shifted = {i_rem[N-1:0], i_dividendBit};
  assign w_diff    = {i_rem, i_dividendBit} - {2'b00, i_divisor};
  assign o_qBit    = ~w_diff[N+1];
  assign o_rem     = o_qBit ? w_diff[N:0] : w_shifted;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider (IDLE -> BUSY x N -> FIX -> DONE).
// Optional macro DIV_EARLY_ZERO_EN: zero divisor skips straight to DONE and raises div_zero_o.
module div_unit
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_zero_o
);

  localparam int CNT_W = cntWidth(N);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N:0]       r_rem;
  logic [N-1:0]     r_quo;
  logic [N-1:0]     r_div;
  logic             r_negQ;
  logic             r_negR;
  logic             r_zero;
  logic             r_divZero;

  logic             w_aNeg;
  logic             w_bNeg;
  logic             w_bZero;
  logic [N-1:0]     w_aMag;
  logic [N-1:0]     w_bMag;
  logic [N:0]       w_remNext;
  logic             w_qBit;
  logic [N-1:0]     w_quoFix;
  logic [N-1:0]     w_remFix;

  assign w_aNeg  = signed_i & a_i[N-1];
  assign w_bNeg  = signed_i & b_i[N-1];
  assign w_bZero = (b_i == '0);
  assign w_aMag  = w_aNeg ? -a_i : a_i;
  assign w_bMag  = w_bNeg ? -b_i : b_i;

  // r_quo starts as the dividend and is shifted out MSB-first as quotient bits shift in.
  div_step #(.N(N)) u_step (
    .i_rem         (r_rem),
    .i_dividendBit (r_quo[N-1]),
    .i_divisor     (r_div),
    .o_rem         (w_remNext),
    .o_qBit        (w_qBit)
  );

  assign w_quoFix   = r_zero ? '1 : (r_negQ ? -r_quo : r_quo);
  assign w_remFix   = r_negR ? -r_rem[N-1:0] : r_rem[N-1:0];
  assign div_zero_o = r_divZero;

  // Status outputs are registered copies of the state, so they lag it by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_zero      <= 1'b0;
      r_divZero   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      busy_o <= (r_state == BUSY) || (r_state == FIX);
      done_o <= (r_state == DONE);
`ifdef DIV_EARLY_ZERO_EN
      r_divZero <= (r_state == DONE) && r_zero;
`else
      r_divZero <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_rem  <= '0;
            r_quo  <= w_aMag;
            r_div  <= w_bMag;
            r_negQ <= w_aNeg ^ w_bNeg;
            r_negR <= w_aNeg;
            r_zero <= w_bZero;
            r_cnt  <= '0;
`ifdef DIV_EARLY_ZERO_EN
            if (w_bZero) begin
              quotient_o  <= '1;
              remainder_o <= a_i;
              r_state     <= DONE;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end
        BUSY: begin
          r_rem <= w_remNext;
          r_quo <= {r_quo[N-2:0], w_qBit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N - 1)) r_state <= FIX;
        end
        FIX: begin
          quotient_o  <= w_quoFix;
          remainder_o <= w_remFix;
          r_state     <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (N=32): directed corner cases plus random
// divides compared against a plain-arithmetic reference model.
module tb_div_unit;

  localparam int N = 32;
`ifdef DIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         signed_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_zero_o;

  int           checkCount = 0;
  int           passCount  = 0;
  int           obsLat;
  int           obsBusy;
  logic [N-1:0] obsQ;
  logic [N-1:0] obsR;
  logic         obsDz;

  div_unit #(.N(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Truncating division semantics, computed in 64 bits so MIN / -1 does not overflow.
  task automatic refModel(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r);
    longint sa, sb, tq, tr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[N-1:0];
      r  = tr[N-1:0];
    end
  endtask

  // Counts edges after the start edge until done_o, tallying busy_o along the way.
  task automatic waitDone();
    obsLat  = -1;
    obsBusy = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_i);
      #1;
      if (busy_o) obsBusy++;
      if (done_o) begin
        obsLat = k;
        obsQ   = quotient_o;
        obsR   = remainder_o;
        obsDz  = div_zero_o;
        break;
      end
    end
    if (obsLat < 0) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk_i);
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    waitDone();
  endtask

  task automatic checkDivide(input string tag, input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] expQ, expR;
    bit early;
    refModel(sgn, a, b, expQ, expR);
    early = EARLY && (b == '0);
    applyStimulus(sgn, a, b);
    if (obsLat >= 0) begin
      checkOutput({tag, "_q"}, 64'(obsQ), 64'(expQ));
      checkOutput({tag, "_r"}, 64'(obsR), 64'(expR));
      checkOutput({tag, "_lat"}, 64'(obsLat), early ? 64'd1 : 64'(N + 2));
      checkOutput({tag, "_busy"}, 64'(obsBusy), early ? 64'd0 : 64'(N + 1));
      checkOutput({tag, "_dz"}, 64'(obsDz), 64'(early));
      @(posedge clk_i);
      #1;
      checkOutput({tag, "_pulse"}, 64'(done_o), 64'd0);
      checkOutput({tag, "_hold"}, 64'(quotient_o), 64'(expQ));
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic         rs;
    int           firstLat, secondLat;
    logic [N-1:0] firstQ, firstR;

    rst_i    = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    #1;
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_q", 64'(quotient_o), 64'd0);
    checkOutput("rst_r", 64'(remainder_o), 64'd0);
    checkOutput("rst_dz", 64'(div_zero_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    checkDivide("u100_7", 1'b0, 32'd100, 32'd7);
    checkDivide("sNeg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    checkDivide("uF9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    checkDivide("sMinNeg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkDivide("uZero", 1'b0, 32'h1234, 32'd0);
    checkDivide("sZero", 1'b1, 32'h1234, 32'd0);
    checkDivide("sNegZero", 1'b1, 32'hFFFF_FF00, 32'd0);

    // Asynchronous reset in the middle of a divide, then an immediate restart.
    @(negedge clk_i);
    signed_i = 1'b0;
    a_i      = 32'd100;
    b_i      = 32'd7;
    start_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    checkOutput("midBusy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("midRst_busy", 64'(busy_o), 64'd0);
    checkOutput("midRst_done", 64'(done_o), 64'd0);
    checkOutput("midRst_q", 64'(quotient_o), 64'd0);
    checkOutput("midRst_r", 64'(remainder_o), 64'd0);
    checkOutput("midRst_dz", 64'(div_zero_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkDivide("afterRst9_3", 1'b0, 32'd9, 32'd3);

    // start_i held high across a divide with the dividend changed mid-run.
    @(negedge clk_i);
    signed_i  = 1'b0;
    a_i       = 32'd100;
    b_i       = 32'd7;
    start_i   = 1'b1;
    firstLat  = -1;
    secondLat = -1;
    firstQ    = '0;
    firstR    = '0;
    @(posedge clk_i);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 5) a_i = 32'd50;
      if (done_o && firstLat < 0) begin
        firstLat = k;
        firstQ   = quotient_o;
        firstR   = remainder_o;
      end else if (done_o && firstLat >= 0) begin
        secondLat = k;
        break;
      end
    end
    start_i = 1'b0;
    checkOutput("hold_lat1", 64'(firstLat), 64'(N + 2));
    checkOutput("hold_q1", 64'(firstQ), 64'd14);
    checkOutput("hold_r1", 64'(firstR), 64'd2);
    checkOutput("hold_lat2", 64'(secondLat), 64'(2 * N + 5));
    checkOutput("hold_q2", 64'(quotient_o), 64'd7);
    checkOutput("hold_r2", 64'(remainder_o), 64'd1);
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = N'($urandom_range(1, 15));
        2:       rb = '1;
        default: rb = $urandom;
      endcase
      checkDivide($sformatf("rnd%0d", i), rs, ra, rb);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
